mem_lsu: RTL and testbench

Load/store unit for the MEM stage: turns the pipeline's single-cycle `MEM_ld`/`MEM_str`/`MEM_byt` controls into a valid/ready request to a multi-cycle data memory and returns load data. It is the initiator side of the data-memory interface. It stalls the pipeline until the access completes and drives `MEM_data_mem` toward writeback. Byte accesses use byte lanes and byte enables on the bus and zero-extend on load.

---
 rtl/mem_lsu.sv | 93 +++++++++
 tb/tb_mem_lsu.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: pipeline ld/str controls to a valid/ready
// data-memory request, with byte lanes and zero-extended byte loads.
module mem_lsu #(
  parameter int XLEN   = 32,
  parameter int BE_W   = XLEN / 8,
  parameter int LANE_W = $clog2(BE_W)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MEM_ld,
  input  logic            MEM_str,
  input  logic            MEM_byt,
  input  logic [XLEN-1:0] MEM_alu_out,
  input  logic [XLEN-1:0] MEM_b2,
  output logic [XLEN-1:0] MEM_data_mem,
  output logic            MEM_stall,
  output logic            req_valid,
  input  logic            req_ready,
  output logic            req_we,
  output logic [XLEN-1:0] req_addr,
  output logic [XLEN-1:0] req_wdata,
  output logic [BE_W-1:0] req_be,
  input  logic            rsp_valid,
  input  logic [XLEN-1:0] rsp_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  state_t state, state_n;

  logic [LANE_W-1:0] lane;
  logic [LANE_W-1:0] lane_in;
  logic              byt_q;
  logic [XLEN-1:0]   ld_data;
  logic [7:0]        rsp_byte;
  logic              go;

  assign go       = MEM_ld | MEM_str;
  assign lane_in  = MEM_alu_out[LANE_W-1:0];
  assign rsp_byte = rsp_rdata[{lane, 3'b000} +: 8];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_be    <= '0;
      lane      <= '0;
      byt_q     <= 1'b0;
      ld_data   <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && go) begin
        req_addr  <= {MEM_alu_out[XLEN-1:LANE_W], {LANE_W{1'b0}}};
        lane      <= lane_in;
        req_we    <= MEM_str;
        byt_q     <= MEM_byt;
        req_be    <= MEM_byt ? (BE_W'(1) << lane_in) : '1;
        req_wdata <= MEM_byt ? {BE_W{MEM_b2[7:0]}} : MEM_b2;
      end
      if (state == WAIT && rsp_valid) begin
        ld_data <= byt_q ? {{(XLEN-8){1'b0}}, rsp_byte} : rsp_rdata;
      end
    end
  end

  // store beats the load when both are raised
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (go) state_n = REQ;
      REQ:  if (req_ready) state_n = req_we ? DONE : WAIT;
      WAIT: if (rsp_valid) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    req_valid    = (state == REQ);
    MEM_stall    = ((state == IDLE) && go) ||
                   (state == REQ) || (state == WAIT);
    MEM_data_mem = MEM_alu_out;
    if (state == DONE && !req_we) MEM_data_mem = ld_data;
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: stores, byte/word loads, backpressure,
// priority, spurious responses and reset mid-transaction.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_ld, MEM_str, MEM_byt;
  logic [31:0] MEM_alu_out, MEM_b2, MEM_data_mem;
  logic        MEM_stall;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;

  int total = 0;
  int bad   = 0;

  int          stalls, hs;
  logic        unstable, tmo;
  logic [31:0] c_addr, c_wd, result;
  logic        c_we;
  logic [3:0]  c_be;

  mem_lsu dut (
    .clk(clk), .rst(rst),
    .MEM_ld(MEM_ld), .MEM_str(MEM_str), .MEM_byt(MEM_byt),
    .MEM_alu_out(MEM_alu_out), .MEM_b2(MEM_b2),
    .MEM_data_mem(MEM_data_mem), .MEM_stall(MEM_stall),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one full access; bench drives ready/response relative to what it sees
  task automatic access(input logic ld, input logic st, input logic by,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int rdly,
                        input int pdly, input logic spur);
    int   vcyc;
    int   since;
    logic hsd;
    stalls = 0; hs = 0; unstable = 0; tmo = 1;
    vcyc = 0; since = 0; hsd = 0; result = '0;
    MEM_ld = ld; MEM_str = st; MEM_byt = by;
    MEM_alu_out = a; MEM_b2 = wd;
    for (int c = 0; c < 60; c++) begin
      req_ready = req_valid && (vcyc >= rdly);
      if (hsd) begin
        since++;
        rsp_valid = (since > pdly);
        rsp_rdata = rsp_valid ? rd : 32'h0;
      end else begin
        rsp_valid = spur;
        rsp_rdata = 32'hBAD0_BAD0;
      end
      #1;
      if (MEM_stall) stalls++;
      if (req_valid) begin
        if (vcyc == 0) begin
          c_addr = req_addr; c_we = req_we;
          c_be = req_be; c_wd = req_wdata;
        end else if ({req_addr, req_we, req_be, req_wdata} !==
                     {c_addr, c_we, c_be, c_wd}) begin
          unstable = 1;
        end
        vcyc++;
        if (req_ready) begin
          hs++;
          hsd = 1;
        end
      end
      if (!MEM_stall) begin
        result = MEM_data_mem;
        tmo = 0;
        break;
      end
      tick();
    end
    tick();
    MEM_ld = 0; MEM_str = 0; MEM_byt = 0;
    req_ready = 0; rsp_valid = 0; rsp_rdata = '0;
    #1;
  endtask

  initial begin
    rst = 1; MEM_ld = 0; MEM_str = 0; MEM_byt = 0;
    MEM_alu_out = 32'h0000_0abc; MEM_b2 = '0;
    req_ready = 0; rsp_valid = 0; rsp_rdata = '0;
    tick(); tick();
    rst = 0;
    #1;
    chk("rst_valid", {31'b0, req_valid}, 32'd0);
    chk("rst_we", {31'b0, req_we}, 32'd0);
    chk("rst_addr", req_addr, 32'h0);
    chk("rst_wdata", req_wdata, 32'h0);
    chk("rst_be", {28'b0, req_be}, 32'h0);
    chk("rst_stall", {31'b0, MEM_stall}, 32'd0);
    chk("rst_data", MEM_data_mem, 32'h0000_0abc);

    // word store
    access(0, 1, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0, 0);
    chk("st_tmo", {31'b0, tmo}, 32'd0);
    chk("st_hs", hs, 32'd1);
    chk("st_addr", c_addr, 32'h10);
    chk("st_we", {31'b0, c_we}, 32'd1);
    chk("st_be", {28'b0, c_be}, 32'hf);
    chk("st_wdata", c_wd, 32'hDEADBEEF);
    chk("st_stall", stalls, 32'd2);
    chk("st_data", result, 32'h10);

    // byte load, lane 2
    access(1, 0, 1, 32'h12, 32'h0, 32'h11AA2233, 0, 0, 0);
    chk("lb2_tmo", {31'b0, tmo}, 32'd0);
    chk("lb2_addr", c_addr, 32'h10);
    chk("lb2_we", {31'b0, c_we}, 32'd0);
    chk("lb2_be", {28'b0, c_be}, 32'h4);
    chk("lb2_data", result, 32'h0000_00AA);
    chk("lb2_stall", stalls, 32'd3);

    // backpressure on a word load
    access(1, 0, 0, 32'h0000_0107, 32'h0, 32'h8765_4321, 4, 3, 0);
    chk("bp_tmo", {31'b0, tmo}, 32'd0);
    chk("bp_stable", {31'b0, unstable}, 32'd0);
    chk("bp_addr", c_addr, 32'h0000_0104);
    chk("bp_be", {28'b0, c_be}, 32'hf);
    chk("bp_stall", stalls, 32'd10);
    chk("bp_data", result, 32'h8765_4321);

    // passthrough
    MEM_alu_out = 32'h1234;
    #1;
    chk("pt_data", MEM_data_mem, 32'h1234);
    chk("pt_stall", {31'b0, MEM_stall}, 32'd0);
    tick();
    chk("pt_valid", {31'b0, req_valid}, 32'd0);
    chk("pt_stall2", {31'b0, MEM_stall}, 32'd0);

    // both ld and str: store wins
    access(1, 1, 0, 32'h30, 32'h0102_0304, 32'h5555_5555, 0, 0, 0);
    chk("pri_we", {31'b0, c_we}, 32'd1);
    chk("pri_stall", stalls, 32'd2);
    chk("pri_data", result, 32'h30);

    // byte store lane 1
    access(0, 1, 1, 32'h21, 32'h7777_77A5, 32'h0, 2, 0, 0);
    chk("sb_addr", c_addr, 32'h20);
    chk("sb_be", {28'b0, c_be}, 32'h2);
    chk("sb_wdata", c_wd, 32'hA5A5_A5A5);
    chk("sb_stall", stalls, 32'd4);

    // reset while in WAIT, then a stray response
    MEM_ld = 1; MEM_alu_out = 32'h44; req_ready = 1;
    tick();
    chk("rw_valid", {31'b0, req_valid}, 32'd1);
    tick();
    req_ready = 0;
    rst = 1; MEM_ld = 0;
    tick();
    rst = 0;
    rsp_valid = 1; rsp_rdata = 32'hFFFF_FFFF;
    #1;
    chk("rw_valid0", {31'b0, req_valid}, 32'd0);
    chk("rw_addr", req_addr, 32'h0);
    chk("rw_be", {28'b0, req_be}, 32'h0);
    chk("rw_stall", {31'b0, MEM_stall}, 32'd0);
    tick();
    rsp_valid = 0;
    #1;
    chk("rw_stall2", {31'b0, MEM_stall}, 32'd0);
    chk("rw_data", MEM_data_mem, 32'h44);

    // spurious responses before WAIT are ignored
    access(1, 0, 0, 32'h20, 32'h0, 32'hCAFE_F00D, 1, 1, 1);
    chk("sp_tmo", {31'b0, tmo}, 32'd0);
    chk("sp_data", result, 32'hCAFE_F00D);
    chk("sp_stall", stalls, 32'd5);

    // top-lane byte load
    access(1, 0, 1, 32'h13, 32'h0, 32'h5A11_2233, 0, 0, 0);
    chk("lb3_be", {28'b0, c_be}, 32'h8);
    chk("lb3_data", result, 32'h0000_005A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
